bnn_layer: RTL and testbench

BNN_LAYER -- requirements
Module: bnn_layer

---
 rtl/bnn_layer.sv | 137 +++++++++++++
 tb/tb_bnn_layer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer.sv
// bnn_layer: one fully-connected binary neural network layer.
// Accepts an IN_W-bit activation vector (1=+1, 0=-1) and evaluates one
// neuron per cycle as XNOR + popcount compared against a per-neuron
// threshold. Weight rows and thresholds are writable at any time.
//
// Optional feature macro: BNN_LAYER_POPCNT_OUT_EN adds pop_out, the
// registered per-neuron popcounts (neuron k in slice k).
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst       - synchronous active-high reset
//   in_data   - binary activation vector
//   in_valid  - in_data valid
//   in_ready  - layer idle and able to accept a vector
//   wr_en     - weight-row write strobe (wr_data is the row)
//   thr_en    - threshold write strobe (wr_data[CNT_W-1:0] is the threshold)
//   wr_addr   - target neuron for writes; out-of-range addresses ignored
//   wr_data   - write payload
//   out_bits  - neuron outputs, bit k = neuron k
//   pop_out   - (optional) per-neuron popcounts
//   out_valid - out_bits valid, held until out_ready
//   out_ready - consumer accepts out_bits
module bnn_layer #(
  parameter int IN_W   = 8,
  parameter int N_NEUR = 4,
  parameter int CNT_W  = $clog2(IN_W + 1)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [IN_W-1:0]                                in_data,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic                                           wr_en,
  input  logic                                           thr_en,
  input  logic [((N_NEUR > 1) ? $clog2(N_NEUR) : 1)-1:0] wr_addr,
  input  logic [IN_W-1:0]                                wr_data,
  output logic [N_NEUR-1:0]                              out_bits,
`ifdef BNN_LAYER_POPCNT_OUT_EN
  output logic [N_NEUR*CNT_W-1:0]                        pop_out,
`endif
  output logic                                           out_valid,
  input  logic                                           out_ready
);

  localparam int ADDR_W = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [IN_W-1:0]   weights [N_NEUR];
  logic [CNT_W-1:0]  thr     [N_NEUR];
  logic [IN_W-1:0]   x;
  logic [ADDR_W-1:0] k;
  logic [CNT_W-1:0]  pop_k;
  logic              fire_k;
  logic              last_k;
  logic              wr_hit;

  function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // XNOR counts agreeing positions; thresholds above IN_W can never be met.
  always_comb begin
    pop_k  = popcount(~(x ^ weights[k]));
    fire_k = (pop_k >= thr[k]);
    last_k = (k == ADDR_W'(N_NEUR - 1));
    wr_hit = ({1'b0, wr_addr} < (ADDR_W + 1)'(N_NEUR));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_k)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath and parameter storage
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      k        <= '0;
      out_bits <= '0;
`ifdef BNN_LAYER_POPCNT_OUT_EN
      pop_out  <= '0;
`endif
      for (int unsigned n = 0; n < N_NEUR; n++) begin
        weights[n] <= '0;
        thr[n]     <= CNT_W'(IN_W / 2);
      end
    end else begin
      if (state == IDLE && in_valid) begin
        x <= in_data;
        k <= '0;
      end
      if (state == CALC) begin
        out_bits[k] <= fire_k;
`ifdef BNN_LAYER_POPCNT_OUT_EN
        pop_out[k*CNT_W +: CNT_W] <= pop_k;
`endif
        k <= last_k ? '0 : k + ADDR_W'(1);
      end
      // Evaluation above reads the pre-write value in the same cycle.
      if (wr_hit && wr_en) begin
        weights[wr_addr] <= wr_data;
      end
      if (wr_hit && thr_en) begin
        thr[wr_addr] <= wr_data[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_bnn_layer.sv
// Self-checking bench for bnn_layer (IN_W=8, N_NEUR=4): directed table,
// hand-written timing corner cases, and randomized vectors against a
// behavioural model built from XNOR-popcount-threshold arithmetic.
module tb_bnn_layer;

  localparam int IN_W   = 8;
  localparam int N_NEUR = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic              thr_en;
  logic [1:0]        wr_addr;
  logic [IN_W-1:0]   wr_data;
  logic [N_NEUR-1:0] out_bits;
`ifdef BNN_LAYER_POPCNT_OUT_EN
  logic [N_NEUR*CNT_W-1:0] pop_out;
`endif
  logic              out_valid;
  logic              out_ready;

  always #5 clk = ~clk;

  bnn_layer #(.IN_W(IN_W), .N_NEUR(N_NEUR), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .thr_en    (thr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_bits  (out_bits),
`ifdef BNN_LAYER_POPCNT_OUT_EN
    .pop_out   (pop_out),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference model state
  logic [IN_W-1:0]  mw   [N_NEUR];
  logic [CNT_W-1:0] mthr [N_NEUR];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0][7:0] w;
    logic [3:0][3:0] t;
    logic [7:0]      x;
    logic [3:0]      exp;
  } vec_t;

  vec_t tbl [5];

  function automatic void model_reset();
    for (int n = 0; n < N_NEUR; n++) begin
      mw[n]   = '0;
      mthr[n] = 4'(IN_W / 2);
    end
  endfunction

  function automatic int model_pop(input logic [7:0] xv, input int n);
    return $countones(~(xv ^ mw[n]));
  endfunction

  function automatic logic [3:0] model_out(input logic [7:0] xv);
    logic [3:0] r;
    for (int n = 0; n < N_NEUR; n++) begin
      r[n] = (model_pop(xv, n) >= int'(mthr[n]));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic do_write(input bit we, input bit te, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = we; thr_en = te; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0; thr_en = 1'b0;
    if (we) mw[a] = d;
    if (te) mthr[a] = d[3:0];
  endtask

  // Presents one vector, measures edges from acceptance to out_valid.
  task automatic run_vector(input string name, input logic [7:0] xv, input logic [3:0] exp);
    int lat;
    @(negedge clk);
    check({name, " ready"}, in_ready, 1);
    in_data = xv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    check({name, " latency"}, lat, N_NEUR);
    check({name, " out_bits"}, out_bits, exp);
  endtask

  task automatic release_out(input int stall);
    for (int i = 0; i < stall; i++) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("ready after release", in_ready, 1);
    check("valid after release", out_valid, 0);
  endtask

  initial begin
    logic [7:0] xv;
    logic [3:0] held;
    bit         bad;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; wr_en = 1'b0; thr_en = 1'b0;
    wr_addr = '0; wr_data = '0; out_ready = 1'b0;

    tbl[0] = '{w: {8'h00, 8'h0F, 8'hFF, 8'hFF}, t: {4'd9, 4'd5, 4'd8, 4'd8}, x: 8'hFF, exp: 4'b0011};
    tbl[1] = '{w: {8'h00, 8'h00, 8'h00, 8'h00}, t: {4'd0, 4'd0, 4'd0, 4'd0}, x: 8'h3C, exp: 4'b1111};
    tbl[2] = '{w: {8'h5B, 8'h5A, 8'hA5, 8'h5A}, t: {4'd8, 4'd8, 4'd8, 4'd8}, x: 8'h5A, exp: 4'b0101};
    tbl[3] = '{w: {8'h00, 8'h00, 8'h00, 8'h00}, t: {4'd9, 4'd8, 4'd1, 4'd0}, x: 8'h00, exp: 4'b0111};
    tbl[4] = '{w: {8'hF3, 8'hF0, 8'hFF, 8'h0F}, t: {4'd5, 4'd5, 4'd5, 4'd5}, x: 8'hF0, exp: 4'b1100};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_bits", out_bits, 0);

    // Default weights 0, thresholds 4
    run_vector("default A5", 8'hA5, 4'hF);
    release_out(0);

    // Directed table
    for (int e = 0; e < 5; e++) begin
      for (int n = 0; n < N_NEUR; n++) begin
        do_write(1'b1, 1'b0, 2'(n), tbl[e].w[n]);
        do_write(1'b0, 1'b1, 2'(n), {4'h0, tbl[e].t[n]});
      end
      run_vector($sformatf("table%0d", e), tbl[e].x, tbl[e].exp);
      release_out(0);
    end

    // Weight and threshold written in one cycle from the same bus
    do_write(1'b1, 1'b1, 2'd1, 8'h03);
    run_vector("dual write 03", 8'h03, model_out(8'h03));
    check("dual write bit1 fires", out_bits[1], 1);
    release_out(0);
    run_vector("dual write FC", 8'hFC, model_out(8'hFC));
    check("dual write bit1 off", out_bits[1], 0);
    release_out(0);

    // Write to neuron 2 in the very cycle neuron 2 is evaluated
    do_reset();
    @(negedge clk);
    in_data = 8'h00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hFF;
    @(posedge clk);
    #1 wr_en = 1'b0;
    mw[2] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    check("same-cycle write valid", out_valid, 1);
    check("same-cycle write old weight", out_bits, 4'hF);
    release_out(0);
    run_vector("new weight used", 8'h00, 4'b1011);
    release_out(0);

    // Stall in DONE with a second vector offered
    run_vector("stall", 8'hA5, model_out(8'hA5));
    held = out_bits;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall out_bits", out_bits, held);
      check("stall in_ready", in_ready, 0);
      check("stall out_valid", out_valid, 1);
      in_data = 8'h5A; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out(0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    check("ignored vector not queued", bad, 0);

    // Reset during the 2nd CALC cycle
    do_write(1'b1, 1'b0, 2'd0, 8'hFF);
    @(negedge clk);
    in_data = 8'h00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    check("abort no out_valid", bad, 0);
    check("abort in_ready", in_ready, 1);
    run_vector("weights cleared", 8'h00, 4'hF);
    release_out(0);

    // Reset beats a simultaneous write
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
    @(posedge clk);
    #1 rst = 1'b0; wr_en = 1'b0;
    model_reset();
    run_vector("reset over write", 8'h00, 4'hF);
    release_out(0);

`ifdef BNN_LAYER_POPCNT_OUT_EN
    do_write(1'b1, 1'b0, 2'd0, 8'hF0);
    run_vector("popcnt", 8'hF3, model_out(8'hF3));
    check("pop_out slice0", pop_out[3:0], 6);
    release_out(0);
`endif

    // Randomized vectors against the model
    for (int it = 0; it < 60; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        do_write(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
      end
      xv = 8'($urandom);
      run_vector($sformatf("random%0d", it), xv, model_out(xv));
`ifdef BNN_LAYER_POPCNT_OUT_EN
      for (int n = 0; n < N_NEUR; n++) begin
        check($sformatf("random%0d pop%0d", it, n), pop_out[n*CNT_W +: CNT_W], model_pop(xv, n));
      end
`endif
      release_out(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
